uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Receive buffer directly downstream of the UART receiver FSM.
- Captures each received character on the receiver's data-ready strobe and holds up to DEPTH characters for the host.
- Presents the oldest character first-word-fall-through; host pops one character per cycle.
- Reports empty, full, occupancy and sticky overflow; optionally gates the receiver's RTS when nearly full.

Parameters:
- DATA_BITS, 8, character width; matches receiver data width.
- DEPTH, 16, storage entries; power of two, >= 2.
- AFULL_THRESH, 12, occupancy at/above which the FIFO is "almost full"; 1 <= AFULL_THRESH <= DEPTH.

Ports:
- Clk  in  1  system clock, all logic on rising edge.
- Rst  in  1  reset, asynchronous, active-high.
- Push_In  in  1  receiver data-ready; a push is the rising edge of this signal.
- Data_In  in  DATA_BITS  receiver character; stable for at least one cycle before and during Push_In high.
- Pop_In  in  1  host pop request, sampled each cycle.
- Rts_In  in  1  receiver ready-to-send.
- Clr_Err_In  in  1  clears Overflow.
- Data_Out  out  DATA_BITS  head character (FWFT); 0 when Empty.
- Empty  out  1  no characters stored.
- Full  out  1  Count == DEPTH.
- Count  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH.
- Overflow  out  1  sticky: a push was dropped.
- Rts_Out  out  1  ready-to-send to the link partner.

Behaviour:
- Reset (async, immediate): write/read pointers 0; Count 0; Empty 1; Full 0; Overflow 0; Data_Out 0; edge-detect register 0. All stored data is discarded, including mid-stream. Storage array is not reset.
- Push detection: register push_d <= Push_In. push = Push_In & ~push_d. A level held high for N cycles is one push. Data_In is captured in the same cycle push is true.
- Pointers: read and write pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. Count is tracked explicitly.
- Pop: pop = Pop_In & ~Empty. A pop on empty is ignored and has no side effect.
- Write: push & (~Full | pop) writes mem[wptr] <= Data_In and increments wptr.
- Read: pop increments rptr. Data_Out = Empty ? 0 : mem[rptr], combinational from registered state.
- Latency: a pushed character is visible on Data_Out and Empty deasserts on the cycle after the push edge.
- Count update:
  - push only: +1.
  - pop only: -1.
  - both: unchanged.
  - push while Full and no pop: dropped.
- Flags: Empty = (Count == 0). Full = (Count == DEPTH). Both derive from registered Count, so they are glitch-free.
- Full with simultaneous push and pop: both accepted; Count stays DEPTH; the new character goes at the tail.
- Empty with simultaneous push and pop: pop ignored, push accepted; Count becomes 1.
- Overflow: set on the cycle a push is dropped. Cleared by Clr_Err_In high. If set and clear occur in the same cycle, set wins.
- No state machine beyond pointers/count. The FIFO never back-pressures the receiver except through Rts_Out.

Optional Feature:
- Macro: UART_RX_FIFO_FLOWCTL_EN.
- Defined: Rts_Out = Rts_In & ~afull. afull is a registered flag:
  - set when the next Count >= AFULL_THRESH;
  - cleared when the next Count < AFULL_THRESH - 1 (one-entry hysteresis; for AFULL_THRESH = 1, clear at next Count == 0);
  - reset value 0.
- Undefined: Rts_Out = Rts_In (pure pass-through); no afull logic is synthesized.

Decomposition:
- Package uart_pkg holds:
  - UART_DATA_BITS default constant;
  - rx_fifo count/pointer width constants, computed via $clog2.
- uart_pkg is shared with the receiver and transmitter.
- One sub-module: uart_edge_det (registered rising-edge detector, async active-high reset). It is reused for Push_In and is usable by the transmitter side.
- Storage is an inferred array inside uart_rx_fifo; no separate RAM module.

Test Plan:
- Reset with Rst=1 mid-stream, after 3 pushes -> Count=0, Empty=1, Full=0, Overflow=0, Data_Out=0 immediately; after release, the next push of 8'hA5 is the head.
- Push 8'h11, 8'h22, 8'h33 (one-cycle strobes), then pop three -> Data_Out sequence 11, 22, 33; Count 3->0; Empty reasserts after the third pop.
- Push_In held high 5 cycles with Data_In=8'h5A -> exactly one entry, Count=1.
- Fill 16 entries, then push 8'hFF -> Full=1, Count=16, Overflow=1; the head is still the first entry. Clr_Err_In -> Overflow=0.
- At Full, push 8'h77 and pop in the same cycle -> Count=16; after 15 further pops, Data_Out=8'h77. At Empty, push and pop together -> Count=1, Data_Out equals the pushed value.
- UART_RX_FIFO_FLOWCTL_EN, Rts_In=1:
  - 12th push -> Rts_Out=0 next cycle;
  - pop to Count=11 -> Rts_Out stays 0;
  - pop to Count=10 -> Rts_Out=1.
  - Without the macro, Rts_Out tracks Rts_In at all occupancies.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants for the receiver, transmitter and rx buffer.
package uart_pkg;
  localparam int UART_DATA_BITS = 8;
  localparam int RX_FIFO_DEPTH = 16;
  localparam int RX_FIFO_AFULL_THRESH = 12;
  function automatic int rx_fifo_ptr_w(input int depth);
    return $clog2(depth);
  endfunction
  localparam int RX_FIFO_PTR_W = rx_fifo_ptr_w(RX_FIFO_DEPTH);
  localparam int RX_FIFO_CNT_W = RX_FIFO_PTR_W + 1;
endpackage

// File: rtl/uart_edge_det.sv
// uart_edge_det: registered rising-edge detector, one-cycle pulse per low-to-high transition.
module uart_edge_det (
  input  logic Clk,
  input  logic Rst,
  input  logic sig,
  output logic rise
);
  logic sig_d;
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) sig_d <= 1'b0;
    else sig_d <= sig;
  assign rise = sig & ~sig_d;
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: FWFT receive buffer behind the UART receiver with occupancy and sticky overflow.
// Define UART_RX_FIFO_FLOWCTL_EN to drop Rts_Out while the buffer is almost full.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = UART_DATA_BITS,
  parameter int DEPTH        = RX_FIFO_DEPTH,
  parameter int AFULL_THRESH = RX_FIFO_AFULL_THRESH
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     Push_In,
  input  logic [DATA_BITS-1:0]     Data_In,
  input  logic                     Pop_In,
  input  logic                     Rts_In,
  input  logic                     Clr_Err_In,
  output logic [DATA_BITS-1:0]     Data_Out,
  output logic                     Empty,
  output logic                     Full,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Overflow,
  output logic                     Rts_Out
);
  localparam int PW = rx_fifo_ptr_w(DEPTH);
  localparam int CW = PW + 1;
  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count_nxt;
  logic push, pop, wr, drop;
  uart_edge_det u_push_edge (.Clk(Clk), .Rst(Rst), .sig(Push_In), .rise(push));
  assign Empty = Count == '0;
  assign Full = Count == CW'(DEPTH);
  assign pop = Pop_In & ~Empty;
  // a pop frees the slot this cycle, so a push at Full still lands at the tail
  assign wr = push & (~Full | pop);
  assign drop = push & Full & ~pop;
  assign count_nxt = Count + CW'(wr) - CW'(pop);
  assign Data_Out = Empty ? '0 : mem[rptr];
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) begin
      wptr <= '0;
      rptr <= '0;
      Count <= '0;
      Overflow <= 1'b0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      Count <= count_nxt;
      Overflow <= drop | (Overflow & ~Clr_Err_In);
    end
  always_ff @(posedge Clk)
    if (wr) mem[wptr] <= Data_In;
`ifdef UART_RX_FIFO_FLOWCTL_EN
  localparam logic [CW-1:0] AF_SET = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AF_CLR = CW'(AFULL_THRESH - 1);
  logic afull;
  // one entry of hysteresis; the ==0 term covers a threshold of 1
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) afull <= 1'b0;
    else afull <= (count_nxt >= AF_SET) ? 1'b1 :
                  ((count_nxt < AF_CLR) || (count_nxt == '0)) ? 1'b0 : afull;
  assign Rts_Out = Rts_In & ~afull;
`else
  assign Rts_Out = Rts_In;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed stimulus with a scoreboard queue checked by a pop monitor.
module tb_uart_rx_fifo;
`ifdef UART_RX_FIFO_FLOWCTL_EN
  localparam bit FC = 1'b1;
`else
  localparam bit FC = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic push_in = 1'b0, pop_in = 1'b0, rts_in = 1'b1, clr_err_in = 1'b0;
  logic [7:0] data_in = 8'h00, data_out;
  logic empty, full, overflow, rts_out;
  logic [4:0] count;
  int n_cmp = 0, n_fail = 0;
  logic [7:0] exp_q[$];

  uart_rx_fifo dut (
    .Clk(clk), .Rst(rst), .Push_In(push_in), .Data_In(data_in), .Pop_In(pop_in),
    .Rts_In(rts_in), .Clr_Err_In(clr_err_in), .Data_Out(data_out), .Empty(empty),
    .Full(full), .Count(count), .Overflow(overflow), .Rts_Out(rts_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted pop must present the oldest expected character.
  always @(negedge clk)
    if (!rst && pop_in && !empty) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL pop_unexpected: got %0h expected nothing", data_out);
      end else chk("pop_data", {24'h0, data_out}, {24'h0, exp_q.pop_front()});
    end

  task automatic push_chr(input logic [7:0] d, input bit acc);
    @(posedge clk); #1;
    push_in = 1'b1;
    data_in = d;
    if (acc) exp_q.push_back(d);
    @(posedge clk); #1;
    push_in = 1'b0;
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      pop_in = 1'b1;
    end
    @(posedge clk); #1;
    pop_in = 1'b0;
  endtask

  task automatic settle;
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    #2;
    chk("rst_count", {27'h0, count}, 0);
    chk("rst_empty", {31'h0, empty}, 1);
    @(negedge clk);
    rst = 1'b0;
    // mid-stream reset discards everything immediately
    push_chr(8'h01, 1'b1);
    push_chr(8'h02, 1'b1);
    push_chr(8'h03, 1'b1);
    settle();
    chk("pre_rst_count", {27'h0, count}, 3);
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    chk("mid_rst_count", {27'h0, count}, 0);
    chk("mid_rst_empty", {31'h0, empty}, 1);
    chk("mid_rst_full", {31'h0, full}, 0);
    chk("mid_rst_ovf", {31'h0, overflow}, 0);
    chk("mid_rst_data", {24'h0, data_out}, 0);
    @(negedge clk);
    rst = 1'b0;
    push_chr(8'hA5, 1'b1);
    settle();
    chk("a5_head", {24'h0, data_out}, 8'hA5);
    pop_n(1);
    // three strobes, then drain
    push_chr(8'h11, 1'b1);
    push_chr(8'h22, 1'b1);
    push_chr(8'h33, 1'b1);
    settle();
    chk("three_count", {27'h0, count}, 3);
    chk("three_empty", {31'h0, empty}, 0);
    pop_n(3);
    settle();
    chk("drain_count", {27'h0, count}, 0);
    chk("drain_empty", {31'h0, empty}, 1);
    // held level is a single push
    @(posedge clk); #1;
    push_in = 1'b1;
    data_in = 8'h5A;
    exp_q.push_back(8'h5A);
    repeat (5) @(posedge clk);
    #1 push_in = 1'b0;
    settle();
    chk("hold_count", {27'h0, count}, 1);
    pop_n(1);
    // fill, overflow, clear
    for (int i = 1; i <= 16; i++) push_chr(8'(i), 1'b1);
    settle();
    chk("fill_full", {31'h0, full}, 1);
    chk("fill_count", {27'h0, count}, 16);
    chk("fill_ovf", {31'h0, overflow}, 0);
    chk("fill_rts", {31'h0, rts_out}, FC ? 0 : 1);
    push_chr(8'hFF, 1'b0);
    settle();
    chk("ovf_set", {31'h0, overflow}, 1);
    chk("ovf_full", {31'h0, full}, 1);
    chk("ovf_count", {27'h0, count}, 16);
    chk("ovf_head", {24'h0, data_out}, 8'h01);
    @(posedge clk); #1;
    clr_err_in = 1'b1;
    @(posedge clk); #1;
    clr_err_in = 1'b0;
    settle();
    chk("ovf_clr", {31'h0, overflow}, 0);
    // push and pop together at Full
    @(posedge clk); #1;
    push_in = 1'b1;
    data_in = 8'h77;
    pop_in = 1'b1;
    exp_q.push_back(8'h77);
    @(posedge clk); #1;
    push_in = 1'b0;
    pop_in = 1'b0;
    settle();
    chk("fullpp_count", {27'h0, count}, 16);
    chk("fullpp_ovf", {31'h0, overflow}, 0);
    pop_n(15);
    settle();
    chk("tail_77", {24'h0, data_out}, 8'h77);
    chk("tail_count", {27'h0, count}, 1);
    pop_n(1);
    settle();
    chk("empty_again", {31'h0, empty}, 1);
    // push and pop together at Empty
    @(posedge clk); #1;
    push_in = 1'b1;
    data_in = 8'h3C;
    pop_in = 1'b1;
    exp_q.push_back(8'h3C);
    @(posedge clk); #1;
    push_in = 1'b0;
    pop_in = 1'b0;
    settle();
    chk("emptypp_count", {27'h0, count}, 1);
    chk("emptypp_data", {24'h0, data_out}, 8'h3C);
    pop_n(1);
    // almost-full hysteresis on Rts_Out
    for (int i = 0; i < 11; i++) push_chr(8'h40 + 8'(i), 1'b1);
    settle();
    chk("rts_at11", {31'h0, rts_out}, 1);
    push_chr(8'h4B, 1'b1);
    settle();
    chk("rts_at12", {31'h0, rts_out}, FC ? 0 : 1);
    pop_n(1);
    settle();
    chk("rts_back11", {31'h0, rts_out}, FC ? 0 : 1);
    pop_n(1);
    settle();
    chk("rts_back10", {31'h0, rts_out}, 1);
    rts_in = 1'b0;
    #1 chk("rts_in_low", {31'h0, rts_out}, 0);
    rts_in = 1'b1;
    pop_n(10);
    settle();
    chk("final_empty", {31'h0, empty}, 1);
    chk("final_queue", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
